// File: rtl/nn_inference_sequencer.sv
// Inference-pass sequencer: clears every stage, walks the layer stages in order, runs argmax,
// and latches the winning digit. A per-stage watchdog aborts a hung pass with a sticky error.
module nn_inference_sequencer #(
    parameter int LAYER_NB = 3,
    parameter int WIDTH    = 4,
    parameter int TIMEOUT  = 1000,
    parameter int TO_W     = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LAYER_NB-1:0] layer_done,
    input  logic                max_done,
    input  logic [WIDTH-1:0]    max_digit,
    output logic                stage_clear,
    output logic [LAYER_NB-1:0] layer_enable,
    output logic                max_enable,
    output logic                busy,
    output logic [WIDTH-1:0]    digit,
    output logic                result_valid,
    output logic                error,
    output logic [2:0]          state_dbg
);

    localparam int K_W = (LAYER_NB > 1) ? $clog2(LAYER_NB) : 1;
    localparam logic [K_W-1:0]      K_LAST   = K_W'(LAYER_NB - 1);
    localparam logic [TO_W-1:0]     CNT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [LAYER_NB-1:0] ONE_HOT0 = LAYER_NB'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        MAX   = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    digit_q, digit_d;
    logic                error_q, error_d;
    logic                stage_clear_q, stage_clear_d;
    logic [LAYER_NB-1:0] layer_enable_q, layer_enable_d;
    logic                max_enable_q, max_enable_d;
    logic                busy_q, busy_d;
    logic                result_valid_q, result_valid_d;

    // Stage handshake: an enable is held until the stage's done flag is sampled high at a
    // rising edge; that edge moves the enable to the next stage with no gap and no overlap.
    // Done flags are level signals that stay high until the stage is cleared, so only the
    // flag of the currently enabled stage is ever looked at.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                k_d     = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (layer_done[k_q]) begin
                    cnt_d = '0;
                    if (k_q == K_LAST) begin
                        state_d = MAX;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MAX: begin
                if (max_done) begin
                    digit_d = max_digit;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                error_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        stage_clear_d  = (state_d == CLEAR);
        layer_enable_d = '0;
        if (state_d == RUN) begin
            layer_enable_d = ONE_HOT0 << k_d;
        end
        max_enable_d   = (state_d == MAX);
        busy_d         = (state_d == CLEAR) || (state_d == RUN) ||
                         (state_d == MAX)   || (state_d == DONE);
        result_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            k_q            <= '0;
            cnt_q          <= '0;
            digit_q        <= '0;
            error_q        <= 1'b0;
            stage_clear_q  <= 1'b0;
            layer_enable_q <= '0;
            max_enable_q   <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            cnt_q          <= cnt_d;
            digit_q        <= digit_d;
            error_q        <= error_d;
            stage_clear_q  <= stage_clear_d;
            layer_enable_q <= layer_enable_d;
            max_enable_q   <= max_enable_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign stage_clear  = stage_clear_q;
    assign layer_enable = layer_enable_q;
    assign max_enable   = max_enable_q;
    assign busy         = busy_q;
    assign digit        = digit_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Directed bench for nn_inference_sequencer: table of full passes plus hand-written
// watchdog and asynchronous-reset sequences, on a default instance and a TIMEOUT=8 instance.
module tb_nn_inference_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] layer_done;
    logic       max_done;
    logic [3:0] max_digit;
    logic       sel;

    logic       a_sc, a_me, a_busy, a_rv, a_err;
    logic [2:0] a_le, a_st;
    logic [3:0] a_dig;
    logic       b_sc, b_me, b_busy, b_rv, b_err;
    logic [2:0] b_le, b_st;
    logic [3:0] b_dig;

    logic       o_sc, o_me, o_busy, o_rv, o_err;
    logic [2:0] o_le, o_st;
    logic [3:0] o_dig;

    int errors;
    int checks;
    logic [3:0] last_digit;

    typedef struct {
        int         n0;
        int         n1;
        int         n2;
        int         nm;
        logic [3:0] dig;
        int         exp_p;
        bit         hold;
    } vec_t;

    vec_t vecs[4];

    nn_inference_sequencer u_dut_a (
        .clk(clk), .reset(reset), .start(start), .layer_done(layer_done),
        .max_done(max_done), .max_digit(max_digit),
        .stage_clear(a_sc), .layer_enable(a_le), .max_enable(a_me), .busy(a_busy),
        .digit(a_dig), .result_valid(a_rv), .error(a_err), .state_dbg(a_st)
    );

    nn_inference_sequencer #(.LAYER_NB(3), .WIDTH(4), .TIMEOUT(8), .TO_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .layer_done(layer_done),
        .max_done(max_done), .max_digit(max_digit),
        .stage_clear(b_sc), .layer_enable(b_le), .max_enable(b_me), .busy(b_busy),
        .digit(b_dig), .result_valid(b_rv), .error(b_err), .state_dbg(b_st)
    );

    assign o_sc   = sel ? b_sc   : a_sc;
    assign o_le   = sel ? b_le   : a_le;
    assign o_me   = sel ? b_me   : a_me;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_dig  = sel ? b_dig  : a_dig;
    assign o_rv   = sel ? b_rv   : a_rv;
    assign o_err  = sel ? b_err  : a_err;
    assign o_st   = sel ? b_st   : a_st;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stage_clear"}, 32'(o_sc), 0);
        chk({tag, "_layer_enable"}, 32'(o_le), 0);
        chk({tag, "_max_enable"}, 32'(o_me), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_digit"}, 32'(o_dig), 0);
        chk({tag, "_result_valid"}, 32'(o_rv), 0);
        chk({tag, "_error"}, 32'(o_err), 0);
        chk({tag, "_state"}, 32'(o_st), 0);
    endtask

    task automatic pulse_reset();
        start      = 1'b0;
        layer_done = '0;
        max_done   = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Called at a drive point while the selected DUT is idle; returns at the drive point of
    // the first idle cycle after the pass, so a following call starts back-to-back.
    task automatic run_pass(input int tag, input int n0, input int n1, input int n2,
                            input int nm, input logic [3:0] dig, input int exp_p, input bit hold);
        int s1, s2, sm;
        logic [2:0] exp_le;
        s1 = 2 + n0;
        s2 = s1 + n1;
        sm = s2 + n2;
        start = 1'b1;
        for (int p = 1; p <= exp_p + 1; p++) begin
            @(posedge clk);
            #1;
            if (!hold || p >= exp_p) start = 1'b0;
            if (p == 1) begin
                layer_done = '0;
                max_done   = 1'b0;
            end
            exp_le = 3'b000;
            if (p >= 2 && p < s1)        exp_le = 3'b001;
            else if (p >= s1 && p < s2)  exp_le = 3'b010;
            else if (p >= s2 && p < sm)  exp_le = 3'b100;
            chk($sformatf("p%0d_stage_clear c%0d", tag, p), 32'(o_sc), 32'(p == 1));
            chk($sformatf("p%0d_layer_enable c%0d", tag, p), 32'(o_le), 32'(exp_le));
            chk($sformatf("p%0d_max_enable c%0d", tag, p), 32'(o_me), 32'(p >= sm && p < exp_p));
            chk($sformatf("p%0d_busy c%0d", tag, p), 32'(o_busy), 32'(p <= exp_p));
            chk($sformatf("p%0d_result_valid c%0d", tag, p), 32'(o_rv), 32'(p == exp_p));
            chk($sformatf("p%0d_digit c%0d", tag, p), 32'(o_dig),
                32'((p >= exp_p) ? dig : last_digit));
            chk($sformatf("p%0d_error c%0d", tag, p), 32'(o_err), 0);
            if (p == s1 - 1)    layer_done[0] = 1'b1;
            if (p == s2 - 1)    layer_done[1] = 1'b1;
            if (p == sm - 1)    layer_done[2] = 1'b1;
            if (p == exp_p - 1) begin
                max_done  = 1'b1;
                max_digit = dig;
            end
        end
        last_digit = dig;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        last_digit = 4'd0;
        reset      = 1'b1;
        start      = 1'b0;
        layer_done = '0;
        max_done   = 1'b0;
        max_digit  = 4'd0;
        sel        = 1'b0;

        // {n0, n1, n2, n_max, digit, result_valid cycle = 2 + sum(n) + n_max, hold start}
        vecs[0] = '{4, 2, 1, 11, 4'd7,  20, 1'b0};
        vecs[1] = '{1, 1, 1, 1,  4'd3,  6,  1'b0};
        vecs[2] = '{2, 5, 3, 2,  4'd9,  14, 1'b0};
        vecs[3] = '{1, 2, 1, 3,  4'd12, 9,  1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_a");
        sel = 1'b1;
        #1;
        check_zero("reset_b");
        sel = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            run_pass(i, vecs[i].n0, vecs[i].n1, vecs[i].n2, vecs[i].nm,
                     vecs[i].dig, vecs[i].exp_p, vecs[i].hold);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_idle_busy c%0d", i), 32'(o_busy), 0);
            chk($sformatf("hold_idle_stage_clear c%0d", i), 32'(o_sc), 0);
            chk($sformatf("hold_idle_state c%0d", i), 32'(o_st), 0);
        end

        // Watchdog instance: one good pass, then layer 1 never reports done.
        sel = 1'b1;
        pulse_reset();
        last_digit = 4'd0;
        run_pass(10, 1, 1, 1, 2, 4'd5, 7, 1'b0);
        start = 1'b1;
        for (int p = 1; p <= 14; p++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (p == 1) begin
                layer_done = '0;
                max_done   = 1'b0;
            end
            chk($sformatf("to_stage_clear c%0d", p), 32'(o_sc), 32'(p == 1));
            chk($sformatf("to_layer_enable c%0d", p), 32'(o_le),
                (p == 2) ? 32'h1 : ((p >= 3 && p <= 10) ? 32'h2 : 32'h0));
            chk($sformatf("to_busy c%0d", p), 32'(o_busy), 32'(p <= 10));
            chk($sformatf("to_error c%0d", p), 32'(o_err), 32'(p >= 12));
            chk($sformatf("to_result_valid c%0d", p), 32'(o_rv), 0);
            chk($sformatf("to_digit c%0d", p), 32'(o_dig), 32'h5);
            if (p == 11) chk("to_state_fault", 32'(o_st), 32'h5);
            if (p == 2) layer_done[0] = 1'b1;
        end
        // Layer 1 and argmax both finish in their last allowed cycle.
        run_pass(11, 1, 8, 1, 8, 4'd6, 20, 1'b0);

        // Asynchronous reset in the middle of the argmax stage.
        sel = 1'b0;
        pulse_reset();
        last_digit = 4'd0;
        start = 1'b1;
        for (int p = 1; p <= 7; p++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (p == 1) begin
                layer_done = '0;
                max_done   = 1'b0;
            end
            if (p == 2) layer_done[0] = 1'b1;
            if (p == 3) layer_done[1] = 1'b1;
            if (p == 4) layer_done[2] = 1'b1;
        end
        chk("midmax_max_enable", 32'(o_me), 1);
        chk("midmax_busy", 32'(o_busy), 1);
        #2 reset = 1'b1;
        #1;
        check_zero("midmax_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_busy", 32'(o_busy), 0);
        chk("post_reset_result_valid", 32'(o_rv), 0);
        run_pass(20, 2, 1, 3, 1, 4'd4, 9, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nn_inference_sequencer.md
# nn_inference_sequencer

Top-level sequencer for one inference pass through the fixed-point network. On a `start` pulse it clears all layer stages and the argmax stage, then enables each layer in turn, waiting for each stage's done flag. It then runs the argmax stage and latches the winning digit with a one-cycle `result_valid` pulse. A per-stage watchdog aborts a hung pass and raises a sticky `error`.

## Interface
Parameters:
- `LAYER_NB`, 3: number of layer stages ahead of the argmax stage (1..8).
- `WIDTH`, 4: digit/index width, matching the argmax stage.
- `TIMEOUT`, 1000: maximum cycles any single stage may run before abort (≥2).
- `TO_W`, 10: watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  inference request; sampled only in IDLE.
- `layer_done`  in  LAYER_NB  per-layer done flags; a flag stays high until that layer is cleared.
- `max_done`  in  1  argmax stage done flag.
- `max_digit`  in  WIDTH  argmax stage index output.
- `stage_clear`  out  1  one-cycle synchronous clear to all layers and the argmax stage.
- `layer_enable`  out  LAYER_NB  one-hot enable of the active layer.
- `max_enable`  out  1  argmax stage enable.
- `busy`  out  1  high from CLEAR through DONE.
- `digit`  out  WIDTH  last successfully inferred digit.
- `result_valid`  out  1  one-cycle pulse when `digit` updates.
- `error`  out  1  sticky watchdog abort flag.

## Operation
- All outputs are registered and decoded from the state, stage index `k`, and watchdog `cnt`.
- States: IDLE, CLEAR, RUN, MAX, DONE, FAULT.
- IDLE: all enables 0. When `start`=1, clear `error` and go to CLEAR.
- CLEAR: `stage_clear`=1 for exactly one cycle. Set `k`=0 and `cnt`=0, then go to RUN.
- RUN: `layer_enable` = one-hot(k). Only `layer_done[k]` is examined; stale done flags of earlier layers are ignored.
  - `layer_done[k]`=1 and k<LAYER_NB-1: k←k+1, `cnt`←0, stay in RUN.
  - `layer_done[k]`=1 and k=LAYER_NB-1: `cnt`←0, go to MAX.
  - Otherwise, if `cnt`=TIMEOUT-1: go to FAULT. Else `cnt`←`cnt`+1.
- MAX: `max_enable`=1.
  - `max_done`=1: `digit`←`max_digit`, go to DONE.
  - Otherwise the same watchdog rule applies.
- DONE: `result_valid`=1 for one cycle, then go to IDLE.
- FAULT: `error`←1 and go to IDLE. `error` holds until the next accepted `start`. `digit` is unchanged.
- `start` outside IDLE is ignored; no queuing.
- Done takes priority over timeout when both occur in the same cycle.
- `digit` keeps its last good value across aborted passes.
- `busy` is 1 in CLEAR, RUN, MAX, and DONE; it is 0 in IDLE and FAULT.

## Timing
- Reset (asynchronous, any state): state=IDLE, k=0, cnt=0. Every output is 0: `stage_clear`, `layer_enable`, `max_enable`, `busy`, `digit`, `result_valid`, `error`.
- Reset mid-pass drops all enables immediately. No `result_valid` is issued for that pass.
- Edge at which `start` is sampled = E0. `stage_clear` is high in cycle E0+1. `layer_enable[0]` is high from cycle E0+2.
- A stage lasts n cycles, where n is the enable cycle in which its done flag is first sampled high (n=1 means done is already high in the first enabled cycle).
- The next stage's enable rises in the cycle right after the done sample. There is no gap cycle, and the two enables never overlap.
- `result_valid` is high in cycle E0 + 2 + Σn_k + n_max. `digit` is valid from that same cycle.
- Fastest pass (every n=1): `result_valid` at E0+LAYER_NB+3.
- Watchdog: done is accepted up to and including enabled cycle TIMEOUT. If it has not been seen, FAULT is entered in cycle TIMEOUT+1 and `error` rises in cycle TIMEOUT+2.
- After DONE or FAULT, a new `start` is accepted in the first IDLE cycle.

## Test plan
- Reset, LAYER_NB=3, layers report done after n=4,2,1 cycles, `max_done` after 11 cycles with `max_digit`=7:
  - `stage_clear` at E0+1.
  - `layer_enable` is 001, 010, 100, each for exactly 4, 2, 1 cycles.
  - `result_valid` at E0+20, `digit`=7, `busy` drops the cycle after.
- Back-to-back passes with digits 3 then 9:
  - second `stage_clear` one cycle after the second `start`;
  - `digit`=3 until the second `result_valid`, then 9.
- `start` held high through an entire pass → exactly one pass. A new pass begins only from IDLE.
- TIMEOUT=8, `layer_done[1]` never rises:
  - `layer_enable`=010 for exactly 8 cycles, then 000;
  - `error`=1, no `result_valid`, `digit` keeps its prior value;
  - next `start` clears `error`.
- `layer_done[1]` first rises exactly in enabled cycle 8 with TIMEOUT=8 → pass completes normally, `error`=0.
- `reset` asserted asynchronously mid-MAX → all outputs 0 immediately, state IDLE; the next `start` runs a full clean pass.
